// File: rtl/fetch_exec_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit accumulator processor.
// Owns PC and instruction registers and runs the single-port memory req/ack handshake.
module fetch_exec_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       acc_zero,
    output logic       fetch,
    output logic [7:0] pc,
    output logic [7:0] irl,
    output logic [7:0] ir_opcode,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] alu_op,
    output logic       acc_load,
    output logic       halted,
    output logic       illegal_op
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;
    localparam logic [7:0] OP_JMP   = 8'h06;
    localparam logic [7:0] OP_JZ    = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'h0F;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    typedef enum logic [2:0] {
        ST_HALT,
        ST_FETCH_OP,
        ST_FETCH_ADDR,
        ST_DECODE,
        ST_EXEC_MEM
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] pc_nxt, irl_nxt, op_nxt;
    logic       is_mem_op, is_defined;

    always_comb begin
        is_mem_op  = 1'b0;
        is_defined = 1'b1;
        case (ir_opcode)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: is_mem_op = 1'b1;
            OP_NOP, OP_JMP, OP_JZ, OP_HALT:             is_defined = 1'b1;
            default:                                    is_defined = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_HALT;
            pc        <= RESET_PC;
            irl       <= 8'h00;
            ir_opcode <= 8'h00;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            irl       <= irl_nxt;
            ir_opcode <= op_nxt;
        end
    end

    // Outputs are decoded from state so an async reset clears them without a clock edge.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        irl_nxt    = irl;
        op_nxt     = ir_opcode;
        fetch      = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        alu_op     = ALU_PASS;
        acc_load   = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            ST_HALT: begin
                halted = 1'b1;
                if (run) state_nxt = ST_FETCH_OP;
            end
            ST_FETCH_OP: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    op_nxt    = mem_rdata;
                    pc_nxt    = pc + 8'd1;
                    state_nxt = ST_FETCH_ADDR;
                end
            end
            ST_FETCH_ADDR: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    irl_nxt   = mem_rdata;
                    pc_nxt    = pc + 8'd1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                fetch      = 1'b0;
                illegal_op = !is_defined;
                state_nxt  = is_mem_op ? ST_EXEC_MEM : ST_FETCH_OP;
                case (ir_opcode)
                    OP_JMP:  pc_nxt = irl;
                    OP_JZ:   if (acc_zero) pc_nxt = irl;
                    OP_HALT: state_nxt = ST_HALT;
                    default: ;
                endcase
            end
            ST_EXEC_MEM: begin
                fetch   = 1'b0;
                mem_req = 1'b1;
                mem_we  = (ir_opcode == OP_STORE);
                case (ir_opcode)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_PASS;
                endcase
                if (mem_ack) begin
                    acc_load  = (ir_opcode != OP_STORE);
                    state_nxt = ST_FETCH_OP;
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Bench for fetch_exec_sequencer: hand vectors, corner sequences and a random
// instruction stream checked against an instruction-level reference model.
module tb_fetch_exec_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, run, mem_ack, acc_zero;
    logic [7:0] mem_rdata;
    logic       fetch, mem_req, mem_we, acc_load, halted, illegal_op;
    logic [7:0] pc, irl, ir_opcode;
    logic [1:0] alu_op;

    always #5 clk = ~clk;

    fetch_exec_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .acc_zero(acc_zero), .fetch(fetch), .pc(pc),
        .irl(irl), .ir_opcode(ir_opcode), .mem_req(mem_req), .mem_we(mem_we),
        .alu_op(alu_op), .acc_load(acc_load), .halted(halted), .illegal_op(illegal_op)
    );

    typedef struct {
        string      nm;
        logic [7:0] spc, op, opd;
        bit         az;
        int         w;
        logic [7:0] epc;
        int         ecyc, eload;
        logic [1:0] ealu;
        int         eill, ewe, ehalt;
    } vec_t;

    logic [7:0] mem [0:255];
    int         checks = 0, failures = 0;
    int         waits = 0, wcnt = 0;
    bit         spur_en = 0;
    bit         pend = 0;
    logic [7:0] pend_addr;
    logic       pend_we;
    logic [7:0] acc_addrs[$];
    int         n_load, n_ill, n_we, n_halt, n_fetch_bad, cyc_i, fetch_len;
    bit         halt_instr;
    logic [1:0] last_alu;
    logic [7:0] we_addr;
    vec_t       tbl[12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // One clock of memory behaviour and observation; entered and left at a negedge.
    task automatic step();
        logic [7:0] a;
        a = fetch ? pc : irl;
        if (mem_req) begin
            if (pend) begin
                chk("hold_addr", a, pend_addr);
                chk("hold_we", mem_we, pend_we);
            end
            mem_ack   = (wcnt == waits);
            mem_rdata = mem_ack ? mem[a] : 8'($urandom);
            if (mem_ack) wcnt = 0; else wcnt++;
            pend      = !mem_ack;
            pend_addr = a;
            pend_we   = mem_we;
        end else begin
            if (pend) chk("hold_req", 0, 1);
            mem_ack   = spur_en && ($urandom_range(0, 1) == 1);
            mem_rdata = 8'($urandom);
            wcnt      = 0;
            pend      = 0;
        end
        #1;
        if (mem_req && mem_ack) begin
            acc_addrs.push_back(a);
            if (mem_we) begin n_we++; we_addr = a; end
        end
        if (acc_load) begin n_load++; last_alu = alu_op; end
        if (illegal_op) n_ill++;
        if (halted) n_halt++;
        if (fetch !== ((cyc_i < fetch_len) || (halt_instr && cyc_i == fetch_len + 1))) n_fetch_bad++;
        cyc_i++;
        @(negedge clk);
    endtask

    task automatic run_instr(input vec_t v);
        logic [7:0] ea;
        int na;
        waits = v.w; acc_zero = v.az;
        n_load = 0; n_ill = 0; n_we = 0; n_halt = 0; n_fetch_bad = 0; cyc_i = 0;
        fetch_len = 2 * (v.w + 1); halt_instr = (v.ehalt > 0);
        acc_addrs.delete();
        chk({v.nm, "_start_pc"}, pc, v.spc);
        chk({v.nm, "_start_fetch"}, {fetch, mem_req, halted}, 3'b110);
        repeat (v.ecyc) step();
        chk({v.nm, "_pc"}, pc, v.epc);
        chk({v.nm, "_next_fetch"}, {fetch, mem_req, halted}, 3'b110);
        chk({v.nm, "_acc_load"}, n_load, v.eload);
        if (v.eload > 0) chk({v.nm, "_alu_op"}, last_alu, v.ealu);
        chk({v.nm, "_illegal"}, n_ill, v.eill);
        chk({v.nm, "_we"}, n_we, v.ewe);
        if (v.ewe > 0) chk({v.nm, "_we_addr"}, we_addr, v.opd);
        chk({v.nm, "_halted"}, n_halt, v.ehalt);
        chk({v.nm, "_fetch_pat"}, n_fetch_bad, 0);
        na = 2 + v.eload + v.ewe;
        chk({v.nm, "_accesses"}, acc_addrs.size(), na);
        for (int i = 0; i < na && i < acc_addrs.size(); i++) begin
            ea = (i == 0) ? v.spc : (i == 1) ? v.spc + 8'd1 : v.opd;
            chk({v.nm, "_addr"}, acc_addrs[i], ea);
        end
    endtask

    // Instruction-level reference: next PC, timing and strobes from the ISA rules.
    function automatic vec_t model(input logic [7:0] p, input bit az, input int w);
        vec_t v;
        int   acc;
        v.nm = "rnd"; v.spc = p; v.op = mem[p]; v.opd = mem[p + 8'd1];
        v.az = az; v.w = w; v.epc = p + 8'd2;
        v.eload = 0; v.ealu = 2'd0; v.eill = 0; v.ewe = 0; v.ehalt = 0; acc = 2;
        case (v.op)
            8'h00: ;
            8'h01: begin v.eload = 1; v.ealu = 2'd0; acc = 3; end
            8'h02: begin v.ewe = 1; acc = 3; end
            8'h03: begin v.eload = 1; v.ealu = 2'd1; acc = 3; end
            8'h04: begin v.eload = 1; v.ealu = 2'd2; acc = 3; end
            8'h05: begin v.eload = 1; v.ealu = 2'd3; acc = 3; end
            8'h06: v.epc = v.opd;
            8'h07: if (az) v.epc = v.opd;
            8'h0F: v.ehalt = 1;
            default: v.eill = 1;
        endcase
        v.ecyc = acc * (w + 1) + 1 + v.ehalt;
        return v;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0; run = 1'b0; mem_ack = 1'b0; acc_zero = 1'b0;
        mem_rdata = 8'h00; spur_en = 0; pend = 0; wcnt = 0; waits = 0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {fetch, mem_req, mem_we, acc_load, illegal_op, halted, alu_op}, 8'b1000_0100);
        chk("rst_regs", {pc, irl, ir_opcode}, 24'h0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        //          nm            spc    op     opd    az  w  epc    cyc ld alu   il we ht
        tbl[0]  = '{"jz_taken",   8'h20, 8'h07, 8'h40, 1, 0, 8'h40, 3,  0, 2'd0, 0, 0, 0};
        tbl[1]  = '{"jz_not",     8'h20, 8'h07, 8'h40, 0, 0, 8'h22, 3,  0, 2'd0, 0, 0, 0};
        tbl[2]  = '{"jmp",        8'h20, 8'h06, 8'h05, 0, 0, 8'h05, 3,  0, 2'd0, 0, 0, 0};
        tbl[3]  = '{"illegal",    8'h20, 8'h55, 8'h77, 0, 0, 8'h22, 3,  0, 2'd0, 1, 0, 0};
        tbl[4]  = '{"nop_ff",     8'hFF, 8'h00, 8'h06, 0, 0, 8'h01, 3,  0, 2'd0, 0, 0, 0};
        tbl[5]  = '{"jmp_ff",     8'hFF, 8'h06, 8'h06, 0, 0, 8'h06, 3,  0, 2'd0, 0, 0, 0};
        tbl[6]  = '{"load_w3",    8'h20, 8'h01, 8'h33, 0, 3, 8'h22, 13, 1, 2'd0, 0, 0, 0};
        tbl[7]  = '{"store_w2",   8'h20, 8'h02, 8'h44, 0, 2, 8'h22, 10, 0, 2'd0, 0, 1, 0};
        tbl[8]  = '{"sub_w1",     8'h30, 8'h04, 8'h10, 0, 1, 8'h32, 7,  1, 2'd2, 0, 0, 0};
        tbl[9]  = '{"and_w0",     8'h30, 8'h05, 8'h11, 1, 0, 8'h32, 4,  1, 2'd3, 0, 0, 0};
        tbl[10] = '{"halt_w1",    8'h20, 8'h0F, 8'h00, 0, 1, 8'h22, 6,  0, 2'd0, 0, 0, 1};
        tbl[11] = '{"jz_fe_w2",   8'hFE, 8'h07, 8'h9A, 1, 2, 8'h9A, 7,  0, 2'd0, 0, 0, 0};

        // Small program, zero-wait memory.
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'h10; mem[2] = 8'h03; mem[3] = 8'h11;
        mem[4] = 8'h02; mem[5] = 8'h12; mem[6] = 8'h0F; mem[7] = 8'h00;
        apply_reset();
        run = 1'b1;
        step();
        run_instr('{"p_load",  8'h00, 8'h01, 8'h10, 0, 0, 8'h02, 4, 1, 2'd0, 0, 0, 0});
        run_instr('{"p_add",   8'h02, 8'h03, 8'h11, 0, 0, 8'h04, 4, 1, 2'd1, 0, 0, 0});
        run_instr('{"p_store", 8'h04, 8'h02, 8'h12, 0, 0, 8'h06, 4, 0, 2'd0, 0, 1, 0});
        run_instr('{"p_halt",  8'h06, 8'h0F, 8'h00, 0, 0, 8'h08, 4, 0, 2'd0, 0, 0, 1});

        // Table vectors, each reached through a JMP at the reset PC.
        foreach (tbl[k]) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            mem[0] = 8'h06; mem[1] = tbl[k].spc;
            mem[tbl[k].spc] = tbl[k].op; mem[tbl[k].spc + 8'd1] = tbl[k].opd;
            apply_reset();
            run = 1'b1;
            step();
            run_instr('{"boot", 8'h00, 8'h06, tbl[k].spc, 0, tbl[k].w, tbl[k].spc,
                        2 * (tbl[k].w + 1) + 1, 0, 2'd0, 0, 0, 0});
            run_instr(tbl[k]);
        end

        // Async reset during an EXEC_MEM wait state.
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'h80;
        apply_reset();
        run = 1'b1; waits = 3;
        repeat (10) step();
        chk("pre_rst_exec", {fetch, mem_req, irl}, {2'b01, 8'h80});
        mem_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_outs", {fetch, mem_req, mem_we, acc_load, illegal_op, halted, alu_op}, 8'b1000_0100);
        chk("async_rst_regs", {pc, irl, ir_opcode}, 24'h0);
        @(negedge clk);
        run = 1'b0; pend = 0; wcnt = 0; spur_en = 1;
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stay_halt", {halted, mem_req, pc}, {2'b10, 8'h00});
            step();
        end
        run = 1'b1;
        step();
        chk("restart_fetch", {fetch, mem_req, halted, pc}, {3'b110, 8'h00});

        // Random instruction stream with random waits, acc_zero and spurious acks.
        for (int i = 0; i < 256; i++)
            case ($urandom_range(0, 11))
                0, 1, 2, 3, 4, 5, 6, 7: mem[i] = 8'($urandom_range(0, 7));
                8:       mem[i] = 8'h0F;
                9:       mem[i] = 8'h55;
                default: mem[i] = 8'($urandom);
            endcase
        apply_reset();
        run = 1'b1;
        step();
        spur_en = 1;
        begin
            logic [7:0] mpc;
            mpc = 8'h00;
            for (int n = 0; n < 300; n++) begin
                v = model(mpc, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
                run_instr(v);
                mpc = v.epc;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
